// File: rtl/fifo.sv
// Synchronous single-clock FIFO with a register-array store, wrap-bit pointers,
// a registered read port and an asynchronous active-low reset.
module fifo #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [DATAWIDTH-1:0] wr_data,
   input  logic                 wr_en,
   input  logic                 rd_en,
   output logic [DATAWIDTH-1:0] rd_data,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fifo: DEPTH must be a power of two and at least 2");
   end

   logic [AW:0]          wr_ptr_q, wr_ptr_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic                 wr_accept;
   logic                 rd_accept;

   // Same index with differing wrap bits means the writer is a full lap ahead.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is deliberately left out of reset; stale words are never readable.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          resetn;
   logic [DW-1:0] wr_data;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          full;
   logic          empty;

   int tests;
   int fails;

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_rd;

   fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rd_data"}, 32'(rd_data), 32'(model_rd));
      check({tag, ".full"},    32'(full),    32'(model_q.size() == DEPTH));
      check({tag, ".empty"},   32'(empty),   32'(model_q.size() == 0));
   endtask

   // Drive on the falling edge, let the model act on the rising edge, sample 1 ns later.
   task automatic step(input string tag, input logic w, input logic [DW-1:0] wd, input logic r);
      bit was_full;
      bit was_empty;
      @(negedge clk);
      wr_en   = w;
      wr_data = wd;
      rd_en   = r;
      @(posedge clk);
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (r && !was_empty) model_rd = model_q.pop_front();
      if (w && !was_full)  model_q.push_back(wd);
      #1;
      check_all(tag);
      $display("[TB] %s wr=%0b wd=%02h rd=%0b -> rd_data=%02h full=%0b empty=%0b",
               tag, w, wd, r, rd_data, full, empty);
   endtask

   initial begin
      logic [DW-1:0] vals [4];
      tests    = 0;
      fails    = 0;
      model_rd = '0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_data  = '0;
      resetn   = 1'b0;

      // Reset state must appear before the first rising edge at 5 ns.
      #2;
      check_all("reset_noclk");
      #18;
      check_all("reset_20ns");
      @(negedge clk);
      resetn = 1'b1;

      // Fill A..D, offer E while full (dropped), then E with a read (A out, E dropped).
      step("fill_A", 1'b1, 8'hA1, 1'b0);
      step("fill_B", 1'b1, 8'hB2, 1'b0);
      step("fill_C", 1'b1, 8'hC3, 1'b0);
      step("fill_D", 1'b1, 8'hD4, 1'b0);
      check("full_after_D", 32'(full), 32'd1);
      step("ovf_E", 1'b1, 8'hE5, 1'b0);
      step("rdfull_E", 1'b1, 8'hE5, 1'b1);
      check("rdfull_gets_A", 32'(rd_data), 32'h0000_00A1);
      check("rdfull_not_full", 32'(full), 32'd0);
      step("drain_B", 1'b0, 8'h00, 1'b1);
      step("drain_C", 1'b0, 8'h00, 1'b1);
      step("drain_D", 1'b0, 8'h00, 1'b1);
      step("drain_extra", 1'b0, 8'h00, 1'b1);
      check("extra_read_holds_D", 32'(rd_data), 32'h0000_00D4);

      // Three fill/drain rounds to exercise pointer wrap.
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < 4; i++) begin
            vals[i] = DW'((round * 16) + (i * 4) + 8'h11);
            step("wrap_fill", 1'b1, vals[i], 1'b0);
         end
         for (int i = 0; i < 4; i++) begin
            step("wrap_drain", 1'b0, 8'h00, 1'b1);
            check("wrap_order", 32'(rd_data), 32'(vals[i]));
         end
      end

      // Simultaneous read/write while empty: only the write lands.
      step("rw_empty", 1'b1, 8'h5A, 1'b1);
      step("rw_mid", 1'b1, 8'h6B, 1'b1);
      step("rd_one", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 200; i++) begin
         step("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      end

      // Mid-operation reset between edges.
      step("pre_rst_w1", 1'b1, 8'h77, 1'b0);
      step("pre_rst_w2", 1'b1, 8'h88, 1'b1);
      @(negedge clk);
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      #1;
      resetn = 1'b0;
      #1;
      model_q.delete();
      model_rd = '0;
      check_all("mid_reset");
      check("mid_reset_rd_zero", 32'(rd_data), 32'd0);
      resetn = 1'b1;
      step("post_rst_w", 1'b1, 8'h3C, 1'b0);
      step("post_rst_r", 1'b0, 8'h00, 1'b1);
      check("post_rst_word", 32'(rd_data), 32'h0000_003C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the storage depth in words; it must be a power of two and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 wr_data  input  DATAWIDTH  write data, sampled when a write is accepted.
REQ-006 wr_en  input  1  write request.
REQ-007 rd_en  input  1  read request.
REQ-008 rd_data  output  DATAWIDTH  registered read data.
REQ-009 full  output  1  high when DEPTH words are stored.
REQ-010 empty  output  1  high when zero words are stored.

Function
REQ-011 Synchronous single-clock first-in-first-out buffer; words are read out in exactly the order written.
REQ-012 Storage: DEPTH x DATAWIDTH register array; write and read pointers each log2(DEPTH)+1 bits wide, the MSB being a wrap bit.
REQ-013 Write accepted on a rising clk edge iff wr_en=1 and full=0; the word goes to mem[wr_ptr index] and wr_ptr increments modulo 2*DEPTH.
REQ-014 Write with full=1 SHALL be dropped silently; memory, pointers and flags are unchanged and no error flag exists.
REQ-015 Read accepted on a rising clk edge iff rd_en=1 and empty=0; rd_data loads mem[rd_ptr index] at that edge and rd_ptr increments modulo 2*DEPTH.
REQ-016 Read latency: data is valid on rd_data immediately after the accepting edge (one-cycle registered read), and holds until the next accepted read.
REQ-017 Read with empty=1 SHALL be ignored; rd_data holds its previous value.
REQ-018 Flags are combinational from the pointers: empty = (wr_ptr == rd_ptr); full = (index bits equal) and (wrap bits differ).
REQ-019 Simultaneous wr_en and rd_en, neither full nor empty: both accepted in the same edge; occupancy is unchanged.
REQ-020 Simultaneous wr_en and rd_en while empty: only the write is accepted; the new word is not forwarded to rd_data that cycle.
REQ-021 Simultaneous wr_en and rd_en while full: only the read is accepted; the write is dropped and the FIFO holds DEPTH-1 words afterwards.
REQ-022 Pointer wrap-around SHALL be seamless; index bits wrap from DEPTH-1 to 0 and the wrap bit toggles.
REQ-023 Inputs are expected to change away from the rising edge (bench drives them on the falling edge); no internal input registering.

Reset
REQ-024 resetn=0 SHALL immediately, without a clock, clear wr_ptr and rd_ptr to 0 and rd_data to 0, giving empty=1 and full=0.
REQ-025 Memory contents need not be cleared by reset; they are not observable until rewritten.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; after release the FIFO is empty and the first accepted write becomes the first word read.
REQ-027 Release of resetn is synchronous-safe: the first accepted operation occurs on the first rising edge with resetn=1.

Verification
REQ-028 Reset check: hold resetn=0 for 20 ns at 100 MHz with wr_en=rd_en=0 -> empty=1, full=0, rd_data=0 with no clock edge needed.
REQ-029 Fill/overflow: DEPTH=4, write 5 words A,B,C,D,E on consecutive cycles -> full=1 after D is accepted, E dropped, empty=0.
REQ-030 Read-while-full: on the cycle E is offered with rd_en=1 and full=1 -> A is read out, E dropped, full=0 afterwards.
REQ-031 Drain: 4 consecutive reads after fill -> rd_data sequence A,B,C,D, one per cycle, empty=1 after D; a fifth read leaves rd_data=D.
REQ-032 Wrap-around: repeat 3 fill-and-drain rounds of 4 words with distinct values -> order preserved every round, flags correct at every edge.
REQ-033 Mid-operation reset: write 2 words, pulse resetn low between edges -> empty=1 and rd_data=0 at once; the next write and read returns the new word.
